// File: rtl/load_store_unit.sv
// Load/store unit bridging the CPU MEM stage to a word-organised data memory.
// Adds byte/halfword access (read-modify-write stores, extended loads) and fault detection.
module load_store_unit #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic [31:0] mwdata_q, mwdata_d;

  logic        accept;
  logic        req_fault;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign req_ready  = (state_q == IDLE) && rst_n;
  assign accept     = req_valid && req_ready;

  assign mem_read   = (state_q == READ);
  assign mem_write  = (state_q == WRITE);
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = mwdata_q;

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;

  // Misalignment, illegal size and out-of-range all abort before any memory strobe.
  always_comb begin
    req_fault = (req_addr >= ADDR_LIMIT);
    case (req_size)
      SZ_BYTE: ;
      SZ_HALF: if (req_addr[0]) req_fault = 1'b1;
      SZ_WORD: if (req_addr[1:0] != 2'b00) req_fault = 1'b1;
      default: req_fault = 1'b1;
    endcase
  end

  // Little-endian lane extraction with sign/zero extension for loads.
  always_comb begin
    lane_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      SZ_BYTE: load_data = {{24{lane_byte[7] & ~unsigned_q}}, lane_byte};
      SZ_HALF: load_data = {{16{lane_half[15] & ~unsigned_q}}, lane_half};
      default: load_data = mem_rdata;
    endcase
  end

  // Sub-word store merge: only the selected lane changes, other bytes pass through.
  always_comb begin
    merged = mem_rdata;
    if (size_q == SZ_HALF) begin
      if (addr_q[1]) merged[31:16] = wdata_q;
      else           merged[15:0]  = wdata_q;
    end else begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    fault_d    = fault_q;
    mwdata_d   = mwdata_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_d     = req_addr;
          wdata_d    = req_wdata[15:0];
          rdata_d    = '0;
          fault_d    = req_fault;
          if (req_fault) begin
            state_d = RESP;
          end else if (req_write && (req_size == SZ_WORD)) begin
            mwdata_d = req_wdata;
            state_d  = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (write_q) begin
          mwdata_d = merged;
          state_d  = WRITE;
        end else begin
          rdata_d = load_data;
          state_d = RESP;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      fault_q    <= 1'b0;
      mwdata_q   <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      fault_q    <= fault_d;
      mwdata_q   <= mwdata_d;
    end
  end

endmodule
